// File: rtl/if_id_pkg.sv
// Shared widths, encodings and beat type for the fetch/decode boundary.
// Also used by fetch, pc and decode so all stages agree on NOP and reset pc.
package if_id_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_ENC      = 32'h00000013;
    localparam logic [XLEN-1:0]   RESET_PC_DEF = 64'h0000000080000000;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [INST_W-1:0] inst;
        logic              misalign;
    } beat_t;

    // RV64 without C extension: any pc not on a 4-byte boundary traps in ID.
    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register: output stage plus a 1-entry skid buffer so that
// back-pressure to fetch is a registered signal.
module if_id
    import if_id_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_ENC,
    parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   inst_addr_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [INST_W-1:0] inst_o,
    output logic              misalign_o,
    output logic              valid_o,
    input  logic              ready_i
);

    beat_t out_beat;
    beat_t skid_beat;
    beat_t in_beat;
    logic  skid_vld;
    logic  accept;
    logic  out_load;

    assign in_beat  = '{addr: inst_addr_i, inst: inst_i, misalign: pc_misaligned(inst_addr_i)};
    // ready_o comes straight from a flop: no combinational path from ready_i.
    assign ready_o  = ~skid_vld;
    assign accept   = valid_i & ready_o;
    assign out_load = ~valid_o | ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o           <= 1'b0;
            out_beat.addr     <= RESET_PC;
            out_beat.inst     <= NOP_INST;
            out_beat.misalign <= 1'b0;
            skid_vld          <= 1'b0;
        end else if (flush_i) begin
            // Redirect: drop everything held and incoming; pc is kept.
            valid_o           <= 1'b0;
            out_beat.inst     <= NOP_INST;
            out_beat.misalign <= 1'b0;
            skid_vld          <= 1'b0;
        end else if (out_load) begin
            if (skid_vld) begin
                out_beat <= skid_beat;
                valid_o  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                out_beat <= in_beat;
                valid_o  <= 1'b1;
            end else begin
                valid_o           <= 1'b0;
                out_beat.inst     <= NOP_INST;
                out_beat.misalign <= 1'b0;
            end
        end else if (accept) begin
            skid_beat <= in_beat;
            skid_vld  <= 1'b1;
        end
    end

    assign inst_addr_o = out_beat.addr;
    assign inst_o      = out_beat.inst;
    assign misalign_o  = out_beat.misalign;

endmodule

// File: tb/tb_if_id.sv
// Scoreboard bench for if_id: a queue-based 2-deep FIFO model predicts the
// visible outputs each cycle; a monitor compares them on the falling edge.
module tb_if_id;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [63:0] RPC = 64'h0000000080000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] inst_addr_i = '0;
    logic [31:0] inst_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        flush_i = 1'b0;
    logic [63:0] inst_addr_o;
    logic [31:0] inst_o;
    logic        misalign_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    always #5 clk = ~clk;

    if_id dut (
        .clk(clk), .rst(rst),
        .inst_addr_i(inst_addr_i), .inst_i(inst_i), .valid_i(valid_i),
        .ready_o(ready_o), .flush_i(flush_i),
        .inst_addr_o(inst_addr_o), .inst_o(inst_o), .misalign_o(misalign_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
    } beat_s;

    typedef struct {
        logic        valid;
        logic [63:0] addr;
        logic [31:0] inst;
        logic        mis;
        logic        ready;
    } exp_s;

    beat_s mq[$];
    exp_s  exp_q[$];
    logic [63:0] last_addr = RPC;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: ID sees the head of a FIFO of at most two beats; fetch may
    // push only while fewer than two are held.
    task automatic model_edge(input logic r, input logic f, input logic v,
                              input logic [63:0] a, input logic [31:0] i, input logic rdy);
        bit can_take;
        beat_s b;
        exp_s e;
        can_take = (mq.size() < 2);
        if (r) begin
            mq.delete();
            last_addr = RPC;
        end else if (f) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (v && can_take) begin
                b.addr = a;
                b.inst = i;
                mq.push_back(b);
            end
        end
        if (mq.size() > 0) last_addr = mq[0].addr;
        e.valid = (mq.size() > 0);
        e.addr  = last_addr;
        e.inst  = e.valid ? mq[0].inst : NOP;
        e.mis   = e.valid ? (last_addr[1:0] != 2'b00) : 1'b0;
        e.ready = (mq.size() < 2);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [63:0] a, input logic [31:0] i, input logic rdy);
        @(negedge clk);
        rst = r; flush_i = f; valid_i = v; inst_addr_i = a; inst_i = i; ready_i = rdy;
        @(posedge clk);
        model_edge(r, f, v, a, i, rdy);
    endtask

    // Monitor: each falling edge consumes one predicted snapshot.
    always @(negedge clk) begin
        exp_s e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_o",     {63'd0, valid_o},    {63'd0, e.valid});
            check("inst_o",      {32'd0, inst_o},     {32'd0, e.inst});
            check("inst_addr_o", inst_addr_o,         e.addr);
            check("misalign_o",  {63'd0, misalign_o}, {63'd0, e.mis});
            check("ready_o",     {63'd0, ready_o},    {63'd0, e.ready});
        end
    end

    initial begin
        logic [63:0] ra;
        // Reset held two cycles with a beat offered.
        step(1, 0, 1, 64'h80000000, 32'h00500093, 1);
        step(1, 0, 1, 64'h80000000, 32'h00500093, 1);
        // Streaming.
        step(0, 0, 1, 64'h80000000, 32'h00500093, 1);
        step(0, 0, 1, 64'h80000004, 32'h00a00113, 1);
        step(0, 0, 0, 64'h0, 32'h0, 1);
        // Stall with skid fill, then drain A, B, C in order.
        step(0, 0, 1, 64'h80000010, 32'h11111111, 1);
        step(0, 0, 1, 64'h80000014, 32'h22222222, 0);
        step(0, 0, 1, 64'h80000018, 32'h33333333, 0);
        step(0, 0, 1, 64'h80000018, 32'h33333333, 1);
        step(0, 0, 1, 64'h80000018, 32'h33333333, 1);
        step(0, 0, 0, 64'h0, 32'h0, 1);
        step(0, 0, 0, 64'h0, 32'h0, 1);
        // Flush with skid full and a beat offered.
        step(0, 0, 1, 64'h80000020, 32'haaaaaaaa, 1);
        step(0, 0, 1, 64'h80000024, 32'hbbbbbbbb, 0);
        step(0, 1, 1, 64'h80000028, 32'hcccccccc, 0);
        step(0, 0, 0, 64'h0, 32'h0, 1);
        // Misaligned then aligned pc.
        step(0, 0, 1, 64'h80000002, 32'h00000073, 1);
        step(0, 0, 1, 64'h80000004, 32'h00100073, 1);
        step(0, 0, 0, 64'h0, 32'h0, 1);
        // Reset while stalled with the skid full.
        step(0, 0, 1, 64'h80000030, 32'hdead0001, 0);
        step(0, 0, 1, 64'h80000034, 32'hdead0002, 0);
        step(1, 0, 1, 64'h80000038, 32'hdead0003, 0);
        step(0, 0, 1, 64'h80000040, 32'h00700193, 1);
        step(0, 0, 0, 64'h0, 32'h0, 1);
        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            ra = {$urandom(), $urandom()};
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) < 7), ra, $urandom(),
                 ($urandom_range(0, 9) < 6));
        end
        step(0, 0, 0, 64'h0, 32'h0, 1);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
